// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state type, counter width and round-robin search for fifo_write_arbiter
package fifo_arb_pkg;

    typedef enum logic {IDLE, BURST} state_t;

    localparam int WORDS_W = 32;
    localparam int MAX_REQ = 16;
    localparam int PICK_W  = 4;

    // Searches upward from last+1 with wrap; the lowest rotated offset wins, so k runs downward
    function automatic logic [PICK_W-1:0] rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [PICK_W-1:0]  last,
        input int                 num
    );
        logic [PICK_W-1:0] pick;
        logic [PICK_W-1:0] j;
        pick = last;
        for (int k = num - 1; k >= 0; k--) begin
            j = PICK_W'((int'(last) + 1 + k) % num);
            if (req[j]) pick = j;
        end
        return pick;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// fifo_write_arbiter_if: producer-side and FIFO write-port signals of fifo_write_arbiter
interface fifo_write_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int N       = 16
);
    import fifo_arb_pkg::*;

    logic [NUM_REQ-1:0]         Req_Valid;
    logic [NUM_REQ*N-1:0]       Req_Data;
    logic [NUM_REQ-1:0]         Req_Ready;
    logic                       Fifo_Full;
    logic                       Fifo_WE;
    logic [N-1:0]               Fifo_Write_Data;
    logic [$clog2(NUM_REQ)-1:0] Grant_Id;
    logic                       Busy;
    logic [WORDS_W-1:0]         Words_Written;

    modport master (
        input  Req_Valid, Req_Data, Fifo_Full,
        output Req_Ready, Fifo_WE, Fifo_Write_Data, Grant_Id, Busy, Words_Written
    );

    modport slave (
        output Req_Valid, Req_Data, Fifo_Full,
        input  Req_Ready, Fifo_WE, Fifo_Write_Data, Grant_Id, Busy, Words_Written
    );

endinterface

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: rotate-and-encode of the request vector starting after the last owner
module rr_priority_picker
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int W       = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [W-1:0]       last,
    output logic [W-1:0]       pick,
    output logic               any
);

    assign any  = |req;
    assign pick = W'(rr_pick(MAX_REQ'(req), PICK_W'(last), NUM_REQ));

endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin arbiter with burst hold sharing one FIFO write port
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int N         = 16,
    parameter int BURST_LEN = 4
) (
    input logic                 Clock,
    input logic                 Reset,
    fifo_write_arbiter_if.master bus
);

    localparam int W = $clog2(NUM_REQ);

    state_t             state;
    logic [W-1:0]       grant_id;
    logic [W-1:0]       last_owner;
    logic [W-1:0]       pick;
    logic [7:0]         beat_cnt;
    logic [WORDS_W-1:0] words;
    logic               any_req;
    logic               busy;
    logic               owner_valid;
    logic               open;
    logic               we;

    rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req  (bus.Req_Valid),
        .last (last_owner),
        .pick (pick),
        .any  (any_req)
    );

    // Reset gates the handshake so an aborted burst never loses or writes a word
    assign busy        = state == BURST;
    assign owner_valid = bus.Req_Valid[grant_id];
    assign open        = busy & ~bus.Fifo_Full & ~Reset;
    assign we          = open & owner_valid;

    assign bus.Req_Ready       = open ? NUM_REQ'(1) << grant_id : '0;
    assign bus.Fifo_WE         = we;
    assign bus.Fifo_Write_Data = bus.Req_Data[int'(grant_id) * N +: N];
    assign bus.Grant_Id        = grant_id;
    assign bus.Busy            = busy;
    assign bus.Words_Written   = words;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_owner <= W'(NUM_REQ - 1);
            beat_cnt   <= '0;
            words      <= '0;
        end else begin
            if (we && words != '1) words <= words + 1'b1;
            if (state == IDLE) begin
                if (any_req) begin
                    state    <= BURST;
                    grant_id <= pick;
                    beat_cnt <= '0;
                end
            end else if (!owner_valid || (we && beat_cnt == 8'(BURST_LEN - 1))) begin
                state      <= IDLE;
                last_owner <= grant_id;
                beat_cnt   <= '0;
            end else if (we) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    assert property (@(posedge Clock) bus.Fifo_WE |-> !bus.Fifo_Full);
    assert property (@(posedge Clock) $onehot0(bus.Req_Ready));

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: vector table, directed corner sequences and randomized model comparison
module tb_fifo_write_arbiter;

    localparam int NR = 4;
    localparam int N  = 16;
    localparam int BL = 4;

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic        full;
        logic [3:0]  ready;
        logic        we;
        logic        busy;
        logic [1:0]  gid;
        logic [31:0] words;
    } vec_t;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int   checks = 0;
    int   passed = 0;

    always #5 Clock = ~Clock;

    fifo_write_arbiter_if #(.NUM_REQ(NR), .N(N)) bus ();

    fifo_write_arbiter #(.NUM_REQ(NR), .N(N), .BURST_LEN(BL)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        bus.Req_Valid = '1;
        bus.Fifo_Full = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b0;
    endtask

    // Reference model: owner index or -1 when idle, plus last owner and beats taken
    int          m_owner, m_grant, m_last, m_beats;
    logic [31:0] m_words;

    task automatic model_reset();
        m_owner = -1;
        m_grant = 0;
        m_last  = NR - 1;
        m_beats = 0;
        m_words = 0;
    endtask

    function automatic int rr_search(input logic [NR-1:0] v);
        for (int i = 1; i <= NR; i++)
            if (v[(m_last + i) % NR]) return (m_last + i) % NR;
        return -1;
    endfunction

    vec_t tbl[20];

    initial begin
        bus.Req_Valid = '1;
        bus.Req_Data  = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
        bus.Fifo_Full = 1'b0;
        tbl = '{
            '{1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 32'd0},
            '{1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 32'd0},
            '{1'b0, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 32'd0},
            '{1'b0, 4'hF, 1'b0, 4'h1, 1'b1, 1'b1, 2'd0, 32'd0},
            '{1'b0, 4'hF, 1'b1, 4'h0, 1'b0, 1'b1, 2'd0, 32'd1},
            '{1'b0, 4'hF, 1'b0, 4'h1, 1'b1, 1'b1, 2'd0, 32'd1},
            '{1'b0, 4'hE, 1'b0, 4'h1, 1'b0, 1'b1, 2'd0, 32'd2},
            '{1'b0, 4'h9, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 32'd2},
            '{1'b0, 4'h9, 1'b0, 4'h8, 1'b1, 1'b1, 2'd3, 32'd2},
            '{1'b0, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1, 2'd3, 32'd3},
            '{1'b0, 4'h1, 1'b0, 4'h0, 1'b0, 1'b0, 2'd3, 32'd3},
            '{1'b0, 4'h1, 1'b0, 4'h1, 1'b1, 1'b1, 2'd0, 32'd3},
            '{1'b0, 4'h1, 1'b0, 4'h1, 1'b1, 1'b1, 2'd0, 32'd4},
            '{1'b0, 4'h1, 1'b0, 4'h1, 1'b1, 1'b1, 2'd0, 32'd5},
            '{1'b0, 4'h1, 1'b0, 4'h1, 1'b1, 1'b1, 2'd0, 32'd6},
            '{1'b0, 4'h1, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 32'd7},
            '{1'b0, 4'h1, 1'b0, 4'h1, 1'b1, 1'b1, 2'd0, 32'd7},
            '{1'b0, 4'h1, 1'b0, 4'h1, 1'b1, 1'b1, 2'd0, 32'd8},
            '{1'b1, 4'h1, 1'b0, 4'h0, 1'b0, 1'b1, 2'd0, 32'd9},
            '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 32'd0}
        };

        @(posedge Clock);
        #1;
        for (int i = 0; i < 20; i++) begin
            Reset         = tbl[i].rst;
            bus.Req_Valid = tbl[i].valid;
            bus.Fifo_Full = tbl[i].full;
            @(negedge Clock);
            chk($sformatf("tbl%0d_ready", i), 32'(bus.Req_Ready), 32'(tbl[i].ready));
            chk($sformatf("tbl%0d_we", i), 32'(bus.Fifo_WE), 32'(tbl[i].we));
            chk($sformatf("tbl%0d_busy", i), 32'(bus.Busy), 32'(tbl[i].busy));
            chk($sformatf("tbl%0d_gid", i), 32'(bus.Grant_Id), 32'(tbl[i].gid));
            chk($sformatf("tbl%0d_words", i), bus.Words_Written, tbl[i].words);
            chk($sformatf("tbl%0d_data", i), 32'(bus.Fifo_Write_Data), 32'h0000_D000 + 32'(tbl[i].gid));
            @(posedge Clock);
            #1;
        end

        // Lone producer 2: two bursts of four separated by one bubble
        begin
            int sent, cyc;
            do_reset();
            bus.Req_Valid = 4'b0100;
            sent = 0;
            cyc  = 0;
            while (sent < 8 && cyc < 40) begin
                bus.Req_Data[2*N +: N] = 16'hA000 + 16'(sent);
                @(negedge Clock);
                cyc++;
                if (bus.Fifo_WE) begin
                    chk("p2_data", 32'(bus.Fifo_Write_Data), 32'h0000_A000 + 32'(sent));
                    sent++;
                end
                @(posedge Clock);
                #1;
            end
            chk("p2_cycles", 32'(cyc), 32'd10);
            @(negedge Clock);
            chk("p2_words", bus.Words_Written, 32'd8);
            @(posedge Clock);
            #1;
        end

        // All producers valid: grants rotate 0,1,2,3,0 with four writes and one bubble each
        begin
            int exp_g[5] = '{0, 1, 2, 3, 0};
            int idle, wr;
            do_reset();
            bus.Req_Valid = 4'hF;
            @(negedge Clock);
            for (int b = 0; b < 5; b++) begin
                idle = 0;
                wr   = 0;
                while (!bus.Busy && idle < 10) begin
                    idle++;
                    @(negedge Clock);
                end
                chk($sformatf("rr%0d_idle", b), 32'(idle), 32'd1);
                chk($sformatf("rr%0d_grant", b), 32'(bus.Grant_Id), 32'(exp_g[b]));
                while (bus.Busy && wr < 20) begin
                    if (bus.Fifo_WE) wr++;
                    @(negedge Clock);
                end
                chk($sformatf("rr%0d_writes", b), 32'(wr), 32'd4);
            end
            @(posedge Clock);
            #1;
        end

        // Producer 1 stalled by Full for three cycles after its second word
        begin
            logic e_we, e_busy;
            do_reset();
            bus.Req_Valid = 4'b0010;
            for (int c = 0; c < 9; c++) begin
                bus.Fifo_Full = (c >= 3 && c <= 5);
                e_we   = (c == 1 || c == 2 || c == 6 || c == 7);
                e_busy = (c >= 1 && c <= 7);
                @(negedge Clock);
                chk($sformatf("stall%0d_we", c), 32'(bus.Fifo_WE), 32'(e_we));
                chk($sformatf("stall%0d_ready", c), 32'(bus.Req_Ready),
                    (e_busy && !bus.Fifo_Full) ? 32'h2 : 32'h0);
                chk($sformatf("stall%0d_busy", c), 32'(bus.Busy), 32'(e_busy));
                if (e_busy) chk($sformatf("stall%0d_gid", c), 32'(bus.Grant_Id), 32'd1);
                @(posedge Clock);
                #1;
            end
        end

        // Randomized traffic against the reference model, including occasional resets
        begin
            logic        e_busy, e_we;
            logic [3:0]  e_ready;
            int          w;
            do_reset();
            model_reset();
            for (int t = 0; t < 400; t++) begin
                Reset = ($urandom_range(0, 99) == 0);
                for (int k = 0; k < NR; k++) bus.Req_Valid[k] = ($urandom_range(0, 3) != 0);
                bus.Fifo_Full = ($urandom_range(0, 3) == 0);
                bus.Req_Data  = {$urandom, $urandom};
                e_busy  = m_owner >= 0;
                e_we    = e_busy && bus.Req_Valid[m_owner] && !bus.Fifo_Full && !Reset;
                e_ready = (e_busy && !bus.Fifo_Full && !Reset) ? 4'(1 << m_owner) : 4'h0;
                @(negedge Clock);
                chk("rnd_ready", 32'(bus.Req_Ready), 32'(e_ready));
                chk("rnd_we", 32'(bus.Fifo_WE), 32'(e_we));
                chk("rnd_busy", 32'(bus.Busy), 32'(e_busy));
                chk("rnd_gid", 32'(bus.Grant_Id), 32'(m_grant));
                chk("rnd_words", bus.Words_Written, m_words);
                chk("rnd_data", 32'(bus.Fifo_Write_Data), 32'(bus.Req_Data[m_grant*N +: N]));
                @(posedge Clock);
                if (Reset) begin
                    model_reset();
                end else begin
                    if (e_we && m_words != 32'hFFFF_FFFF) m_words++;
                    if (!e_busy) begin
                        w = rr_search(bus.Req_Valid);
                        if (w >= 0) begin
                            m_owner = w;
                            m_grant = w;
                            m_beats = 0;
                        end
                    end else if (!bus.Req_Valid[m_owner]) begin
                        m_last  = m_owner;
                        m_owner = -1;
                    end else if (e_we) begin
                        m_beats++;
                        if (m_beats == BL) begin
                            m_last  = m_owner;
                            m_owner = -1;
                        end
                    end
                end
                #1;
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
